pacman_motion: RTL and testbench

//  Player (Pac-Man) motion and life controller; drives the BallX/BallY that every ghost module consumes.

---
 rtl/pacman_motion.sv | 190 +++++++++++++++++++
 tb/tb_pacman_motion.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pacman_motion.sv
// Pac-Man motion and life controller: queued turns applied at 32x32 tile alignment,
// plus an IDLE/PLAY/DYING/OVER life FSM that respawns the player and pulses ghost_reset.
module pacman_motion #(
    parameter logic [9:0] Ball_X_Start = 10'd288,
    parameter logic [9:0] Ball_Y_Start = 10'd352,
    parameter logic [9:0] Ball_Step    = 10'd1,
    parameter logic [1:0] LIVES        = 2'd3,
    parameter logic [7:0] DEATH_FRAMES = 8'd60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       game_reset,
    input  logic       game_on,
    input  logic [7:0] keycode,
    input  logic [3:0] wall,
    input  logic [3:0] ghost_hit,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [1:0] Direction,
    output logic [1:0] lives,
    output logic       ghost_reset,
    output logic       game_over,
    output logic [1:0] state_o,
    output logic       moving_o,
    output logic       queue_valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [1:0] dir_q, dir_d;
    logic       moving_q, moving_d;
    logic [1:0] qdir_q, qdir_d;
    logic       qvalid_q, qvalid_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] timer_q, timer_d;
    logic       ghost_reset_q, ghost_reset_d;
    logic       grace_q, grace_d;
    logic       game_over_q, game_over_d;
    logic       aligned;

    // Bit of the wall mask that tells whether direction d is open.
    function automatic logic [1:0] wall_idx(input logic [1:0] d);
        case (d)
            DIR_UP:    wall_idx = 2'd3;
            DIR_DOWN:  wall_idx = 2'd2;
            DIR_LEFT:  wall_idx = 2'd1;
            default:   wall_idx = 2'd0;
        endcase
    endfunction

    assign aligned = (x_q[4:0] == 5'd0) && (y_q[4:0] == 5'd0);

    always_ff @(posedge frame_clk) begin
        if (Reset || game_reset) begin
            state_q       <= IDLE;
            x_q           <= Ball_X_Start;
            y_q           <= Ball_Y_Start;
            dir_q         <= DIR_UP;
            moving_q      <= 1'b0;
            qdir_q        <= DIR_UP;
            qvalid_q      <= 1'b0;
            lives_q       <= LIVES;
            timer_q       <= 8'd0;
            ghost_reset_q <= 1'b0;
            grace_q       <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            dir_q         <= dir_d;
            moving_q      <= moving_d;
            qdir_q        <= qdir_d;
            qvalid_q      <= qvalid_d;
            lives_q       <= lives_d;
            timer_q       <= timer_d;
            ghost_reset_q <= ghost_reset_d;
            grace_q       <= grace_d;
            game_over_q   <= game_over_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        dir_d         = dir_q;
        moving_d      = moving_q;
        qdir_d        = qdir_q;
        qvalid_d      = qvalid_q;
        lives_d       = lives_q;
        timer_d       = timer_q;
        ghost_reset_d = 1'b0;
        game_over_d   = game_over_q;
        // Grace covers the ghost_reset frame and one more, while the ghosts' die flags clear.
        grace_d       = grace_q;
        if (ghost_reset_q) begin
            grace_d = 1'b1;
        end else if (game_on) begin
            grace_d = 1'b0;
        end

        if (game_on) begin
            case (state_q)
                IDLE: state_d = PLAY;

                PLAY: begin
                    if ((|ghost_hit) && !ghost_reset_q && !grace_q) begin
                        lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                        timer_d = 8'd0;
                        state_d = DYING;
                    end else begin
                        case (keycode)
                            8'h1A: begin qdir_d = DIR_UP;    qvalid_d = 1'b1; end
                            8'h16: begin qdir_d = DIR_DOWN;  qvalid_d = 1'b1; end
                            8'h04: begin qdir_d = DIR_LEFT;  qvalid_d = 1'b1; end
                            8'h07: begin qdir_d = DIR_RIGHT; qvalid_d = 1'b1; end
                            default: ;
                        endcase
                        if (aligned) begin
                            if (qvalid_d && wall[wall_idx(qdir_d)]) begin
                                dir_d    = qdir_d;
                                moving_d = 1'b1;
                                qvalid_d = 1'b0;
                            end else if (!(moving_q && wall[wall_idx(dir_q)])) begin
                                moving_d = 1'b0;
                            end
                        end else if (qvalid_d && (qdir_d == (dir_q ^ 2'b01))) begin
                            dir_d    = qdir_d;
                            qvalid_d = 1'b0;
                        end
                        if (moving_d) begin
                            case (dir_d)
                                DIR_UP:    y_d = y_q - Ball_Step;
                                DIR_DOWN:  y_d = y_q + Ball_Step;
                                DIR_RIGHT: x_d = x_q + Ball_Step;
                                default:   x_d = x_q - Ball_Step;
                            endcase
                        end
                    end
                end

                DYING: begin
                    if (timer_q == DEATH_FRAMES - 8'd1) begin
                        if (lives_q == 2'd0) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                        end else begin
                            x_d           = Ball_X_Start;
                            y_d           = Ball_Y_Start;
                            dir_d         = DIR_UP;
                            moving_d      = 1'b0;
                            qvalid_d      = 1'b0;
                            timer_d       = 8'd0;
                            ghost_reset_d = 1'b1;
                            state_d       = PLAY;
                        end
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end

                default: ;
            endcase
        end
    end

    assign BallX         = x_q;
    assign BallY         = y_q;
    assign Direction     = dir_q;
    assign lives         = lives_q;
    assign ghost_reset   = ghost_reset_q;
    assign game_over     = game_over_q;
    assign state_o       = state_q;
    assign moving_o      = moving_q;
    assign queue_valid_o = qvalid_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: expected values queued before each step, popped and
// compared once the frame edge has produced them.
module tb_pacman_motion;

    logic       frame_clk = 1'b0;
    logic       Reset, game_reset, game_on;
    logic [7:0] keycode;
    logic [3:0] wall, ghost_hit;
    logic [9:0] BallX, BallY;
    logic [1:0] Direction, lives, state_o;
    logic       ghost_reset, game_over, moving_o, queue_valid_o;

    logic [15:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    localparam logic [15:0] S_IDLE = 16'd0, S_PLAY = 16'd1, S_DYING = 16'd2, S_OVER = 16'd3;

    pacman_motion dut (
        .frame_clk(frame_clk), .Reset(Reset), .game_reset(game_reset), .game_on(game_on),
        .keycode(keycode), .wall(wall), .ghost_hit(ghost_hit),
        .BallX(BallX), .BallY(BallY), .Direction(Direction), .lives(lives),
        .ghost_reset(ghost_reset), .game_over(game_over),
        .state_o(state_o), .moving_o(moving_o), .queue_valid_o(queue_valid_o)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic exp(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed %0d but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; game_reset = 1'b0; game_on = 1'b0;
        keycode = 8'h00; wall = 4'b0000; ghost_hit = 4'b0000;
        tick(2);
        Reset = 1'b0;

        // Reset state, held while game_on is low
        exp(288); exp(352); exp(0); exp(3); exp(0); exp(0); exp(S_IDLE);
        tick(1);
        chk("rst_x", BallX); chk("rst_y", BallY); chk("rst_dir", Direction);
        chk("rst_lives", lives); chk("rst_gr", ghost_reset); chk("rst_go", game_over);
        chk("rst_state", state_o);

        // Start: first frame only leaves IDLE, second frame turns right and moves
        game_on = 1'b1; wall = 4'b0001; keycode = 8'h07;
        exp(288); exp(S_PLAY);
        tick(1);
        chk("t1_idle_x", BallX); chk("t1_state", state_o);
        exp(289); exp(2);
        tick(1);
        chk("t1_x289", BallX); chk("t1_dir", Direction);
        keycode = 8'h00;
        exp(320); exp(2);
        tick(31);
        chk("t1_x320", BallX); chk("t1_dir320", Direction);
        exp(332);
        tick(12);
        chk("t1_x332", BallX);

        // Mid-tile reversal takes effect at once
        keycode = 8'h04;
        exp(331); exp(3); exp(0);
        tick(1);
        chk("t3_x", BallX); chk("t3_dir", Direction); chk("t3_qv", queue_valid_o);
        keycode = 8'h07;
        exp(332); exp(2);
        tick(1);
        chk("t3b_x", BallX); chk("t3b_dir", Direction);

        // Queued perpendicular turn waits for tile alignment at X=352
        keycode = 8'h1A; wall = 4'b1001;
        exp(333); exp(2); exp(1);
        tick(1);
        chk("t2_x", BallX); chk("t2_dir", Direction); chk("t2_qv", queue_valid_o);
        keycode = 8'h00;
        exp(352); exp(2);
        tick(19);
        chk("t2_x352", BallX); chk("t2_dir352", Direction);
        exp(352); exp(351); exp(0); exp(0);
        tick(1);
        chk("t2_turn_x", BallX); chk("t2_turn_y", BallY); chk("t2_turn_dir", Direction);
        chk("t2_turn_qv", queue_valid_o);

        // Blocked at alignment: stop, position constant
        wall = 4'b0000;
        exp(320);
        tick(31);
        chk("t4_y320", BallY);
        exp(320); exp(352); exp(0);
        tick(11);
        chk("t4_hold_y", BallY); chk("t4_hold_x", BallX); chk("t4_moving", moving_o);
        keycode = 8'h16;
        exp(320); exp(0); exp(1);
        tick(1);
        chk("t4_keep_y", BallY); chk("t4_keep_mv", moving_o); chk("t4_keep_qv", queue_valid_o);
        keycode = 8'h00; wall = 4'b0100;
        exp(321); exp(1); exp(1);
        tick(1);
        chk("t4_go_y", BallY); chk("t4_go_dir", Direction); chk("t4_go_mv", moving_o);

        // First hit: frozen 60 frames, then respawn with a single ghost_reset pulse
        ghost_hit = 4'b0100; keycode = 8'h1A;
        exp(2); exp(S_DYING); exp(321);
        tick(1);
        chk("t5_lives", lives); chk("t5_state", state_o); chk("t5_y", BallY);
        exp(S_DYING); exp(321); exp(0);
        tick(59);
        chk("t5_dying", state_o); chk("t5_frozen_y", BallY); chk("t5_gr_low", ghost_reset);
        exp(288); exp(352); exp(0); exp(1); exp(S_PLAY);
        tick(1);
        chk("t5_rx", BallX); chk("t5_ry", BallY); chk("t5_rdir", Direction);
        chk("t5_gr", ghost_reset); chk("t5_rstate", state_o);
        keycode = 8'h00;
        exp(0); exp(S_PLAY); exp(2);
        tick(1);
        chk("t5_gr_pulse", ghost_reset); chk("t5_grace1", state_o); chk("t5_grace_lives", lives);
        exp(S_PLAY);
        tick(1);
        chk("t5_grace2", state_o);
        exp(1); exp(S_DYING);
        tick(1);
        chk("t5_hit2_lives", lives); chk("t5_hit2_state", state_o);

        // Second death with a freeze in the middle: timer must hold
        ghost_hit = 4'b0000;
        tick(30);
        game_on = 1'b0;
        exp(S_DYING);
        tick(5);
        chk("t5_freeze", state_o);
        game_on = 1'b1;
        exp(S_DYING);
        tick(29);
        chk("t5_still_dying", state_o);
        exp(S_PLAY); exp(1);
        tick(1);
        chk("t5_resp2", state_o); chk("t5_gr2", ghost_reset);
        game_on = 1'b0;
        exp(0); exp(S_PLAY);
        tick(1);
        chk("t5_gr_off", ghost_reset); chk("t5_off_state", state_o);
        game_on = 1'b1;
        tick(2);

        // Third hit: game over, keys ignored, game_reset restores
        wall = 4'b0001; keycode = 8'h07;
        exp(289);
        tick(1);
        chk("t6_x", BallX);
        keycode = 8'h00; ghost_hit = 4'b0001;
        exp(0); exp(289); exp(S_DYING);
        tick(1);
        chk("t6_lives", lives); chk("t6_x_hit", BallX); chk("t6_state", state_o);
        keycode = 8'h04;
        exp(S_DYING); exp(0);
        tick(59);
        chk("t6_dying", state_o); chk("t6_go_low", game_over);
        exp(S_OVER); exp(1); exp(289);
        tick(1);
        chk("t6_over", state_o); chk("t6_go", game_over); chk("t6_over_x", BallX);
        exp(S_OVER); exp(289);
        tick(5);
        chk("t6_over_hold", state_o); chk("t6_over_hold_x", BallX);
        game_reset = 1'b1;
        exp(288); exp(3); exp(0); exp(S_IDLE);
        tick(1);
        game_reset = 1'b0;
        chk("t6_gr_x", BallX); chk("t6_gr_lives", lives); chk("t6_gr_go", game_over);
        chk("t6_gr_state", state_o);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected values never compared, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
